// File: rtl/latch_output_monitor.sv
// Synchronizes the asynchronous latch output into the clk_in domain, optionally filters short pulses,
// and reports rise/fall strobes plus a saturating transition count. Optional filter: `define GLITCH_FILTER_EN.
module latch_output_monitor #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 q_in,
   input  logic                 clear_in,
   output logic                 q_sync_out,
   output logic                 rise_out,
   output logic                 fall_out,
   output logic [CNT_WIDTH-1:0] count_out,
   output logic                 sat_out
);

   // Reject illegal configurations at elaboration time.
   if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_bad_params
      $error("latch_output_monitor: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
   end

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   s_level;
   logic                   q_next;
   logic                   prev_level;
   logic                   transition;

   assign s_level = sync_chain[SYNC_STAGES-1];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], q_in};
      end
   end

`ifdef GLITCH_FILTER_EN
   // fcnt counts consecutive edges of disagreement; the new level is taken on the FILTER_CYCLES-th one.
   localparam int FW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

   logic [FW-1:0] fcnt;
   logic [FW-1:0] fcnt_next;

   always_comb begin
      q_next    = q_sync_out;
      fcnt_next = '0;
      if (s_level != q_sync_out) begin
         if (fcnt == FW'(FILTER_CYCLES - 1)) begin
            q_next = s_level;
         end else begin
            fcnt_next = fcnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         fcnt <= '0;
      end else begin
         fcnt <= fcnt_next;
      end
   end
`else
   assign q_next = s_level;
`endif

   assign transition = (q_next != q_sync_out);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         q_sync_out <= 1'b0;
         prev_level <= 1'b0;
      end else begin
         q_sync_out <= q_next;
         prev_level <= q_sync_out;
      end
   end

   // Clear beats a simultaneous transition; the level and strobe still update.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_out <= '0;
      end else if (clear_in) begin
         count_out <= '0;
      end else if (transition && !sat_out) begin
         count_out <= count_out + CNT_WIDTH'(1);
      end
   end

   assign sat_out  = &count_out;
   assign rise_out = q_sync_out & ~prev_level & ~rst_in;
   assign fall_out = ~q_sync_out & prev_level & ~rst_in;

endmodule

// File: tb/tb_latch_output_monitor.sv
// Directed testbench for latch_output_monitor; covers both GLITCH_FILTER_EN builds.
module tb_latch_output_monitor;

   localparam int SYNC = 2;
   localparam int FILT = 4;
   localparam int CW   = 4;
`ifdef GLITCH_FILTER_EN
   localparam int LAT = SYNC + FILT;
`else
   localparam int LAT = SYNC + 1;
`endif

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic          q_in;
   logic          clear_in;
   logic          q_sync_out;
   logic          rise_out;
   logic          fall_out;
   logic [CW-1:0] count_out;
   logic          sat_out;

   int errors = 0;
   int checks = 0;

   latch_output_monitor #(
      .SYNC_STAGES  (SYNC),
      .FILTER_CYCLES(FILT),
      .CNT_WIDTH    (CW)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .q_in      (q_in),
      .clear_in  (clear_in),
      .q_sync_out(q_sync_out),
      .rise_out  (rise_out),
      .fall_out  (fall_out),
      .count_out (count_out),
      .sat_out   (sat_out)
   );

   always #5 clk_in = ~clk_in;

   // Returns 1 time unit after a rising edge so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in   = 1'b1;
      q_in     = 1'b1;
      clear_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({q_sync_out, rise_out, fall_out, sat_out, count_out} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs cycle %0d: got q=%b r=%b f=%b s=%b c=%0d, want all 0",
                     i, q_sync_out, rise_out, fall_out, sat_out, count_out);
         end
      end
      rst_in = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         if (k < LAT) begin
            checks++;
            if (q_sync_out !== 1'b0) begin
               errors++;
               $display("[TB] FAIL release_early edge %0d: got q=%b, want 0", k, q_sync_out);
            end
         end else begin
            checks++;
            if ({q_sync_out, rise_out, fall_out} !== 3'b110 || count_out !== CW'(1)) begin
               errors++;
               $display("[TB] FAIL release_accept: got q=%b r=%b f=%b c=%0d, want q=1 r=1 f=0 c=1",
                        q_sync_out, rise_out, fall_out, count_out);
            end
         end
      end
      tick();
      checks++;
      if (rise_out !== 1'b0 || q_sync_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL release_strobe_width: got r=%b q=%b, want r=0 q=1", rise_out, q_sync_out);
      end
   endtask

`ifdef GLITCH_FILTER_EN
   task automatic test_glitch();
      q_in = 1'b0;
      tick();
      tick();
      q_in = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (q_sync_out !== 1'b1 || rise_out !== 1'b0 || fall_out !== 1'b0 || count_out !== CW'(1)) begin
            errors++;
            $display("[TB] FAIL glitch_dropped cycle %0d: got q=%b r=%b f=%b c=%0d, want q=1 r=0 f=0 c=1",
                     k, q_sync_out, rise_out, fall_out, count_out);
         end
      end
      // A 4-cycle low pulse on q_in survives the filter.
      q_in = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 4) q_in = 1'b1;
         if (k == 6) begin
            checks++;
            if (q_sync_out !== 1'b0 || fall_out !== 1'b1 || count_out !== CW'(2)) begin
               errors++;
               $display("[TB] FAIL pulse_fall: got q=%b f=%b c=%0d, want q=0 f=1 c=2",
                        q_sync_out, fall_out, count_out);
            end
         end
         if (k == 10) begin
            checks++;
            if (q_sync_out !== 1'b1 || rise_out !== 1'b1 || count_out !== CW'(3)) begin
               errors++;
               $display("[TB] FAIL pulse_rise: got q=%b r=%b c=%0d, want q=1 r=1 c=3",
                        q_sync_out, rise_out, count_out);
            end
         end
      end
   endtask
`else
   task automatic test_no_filter();
      q_in = 1'b0;
      repeat (LAT + 2) tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++;
      if (count_out !== '0 || q_sync_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL nofilt_setup: got c=%0d q=%b, want c=0 q=0", count_out, q_sync_out);
      end
      q_in = 1'b1;
      tick();
      q_in = 1'b0;
      tick();
      tick();
      checks++;
      if (q_sync_out !== 1'b1 || rise_out !== 1'b1 || count_out !== CW'(1)) begin
         errors++;
         $display("[TB] FAIL nofilt_rise: got q=%b r=%b c=%0d, want q=1 r=1 c=1",
                  q_sync_out, rise_out, count_out);
      end
      tick();
      checks++;
      if (q_sync_out !== 1'b0 || fall_out !== 1'b1 || count_out !== CW'(2)) begin
         errors++;
         $display("[TB] FAIL nofilt_fall: got q=%b f=%b c=%0d, want q=0 f=1 c=2",
                  q_sync_out, fall_out, count_out);
      end
   endtask
`endif

   // Toggles q_in n_toggles times, 10 cycles apart, and returns the strobe counts observed.
   task automatic run_toggles(input int n_toggles, output int n_rise, output int n_fall);
      logic rise_d = 1'b0;
      logic fall_d = 1'b0;
      n_rise = 0;
      n_fall = 0;
      for (int i = 0; i < n_toggles * 10 + 5; i++) begin
         if (i % 10 == 0 && i < n_toggles * 10) q_in = ~q_in;
         tick();
         if (rise_out === 1'b1) n_rise++;
         if (fall_out === 1'b1) n_fall++;
         checks++;
         if ((rise_out & fall_out) !== 1'b0 || (rise_out & rise_d) !== 1'b0 || (fall_out & fall_d) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL strobe_shape cycle %0d: got r=%b f=%b (prev r=%b f=%b), want single exclusive pulses",
                     i, rise_out, fall_out, rise_d, fall_d);
         end
         rise_d = rise_out;
         fall_d = fall_out;
      end
   endtask

   task automatic test_toggle();
      int nr;
      int nf;
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++;
      if (count_out !== '0 || sat_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL toggle_clear: got c=%0d s=%b, want c=0 s=0", count_out, sat_out);
      end
      run_toggles(10, nr, nf);
      checks++;
      if (nr !== 5 || nf !== 5) begin
         errors++;
         $display("[TB] FAIL toggle_strobes: got rises=%0d falls=%0d, want 5 and 5", nr, nf);
      end
      checks++;
      if (count_out !== CW'(10) || sat_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL toggle_count: got c=%0d s=%b, want c=10 s=0", count_out, sat_out);
      end
   endtask

   task automatic test_saturation();
      int nr;
      int nf;
      run_toggles(10, nr, nf);
      checks++;
      if (count_out !== CW'(15) || sat_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL sat_hold: got c=%0d s=%b, want c=15 s=1", count_out, sat_out);
      end
      checks++;
      if (nr !== 5 || nf !== 5) begin
         errors++;
         $display("[TB] FAIL sat_strobes: got rises=%0d falls=%0d, want 5 and 5", nr, nf);
      end
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++;
      if (count_out !== '0 || sat_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sat_clear: got c=%0d s=%b, want c=0 s=0", count_out, sat_out);
      end
   endtask

   task automatic test_simultaneous();
      q_in = 1'b0;
      repeat (LAT + 2) tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++;
      if (count_out !== '0 || q_sync_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL simul_setup: got c=%0d q=%b, want c=0 q=0", count_out, q_sync_out);
      end
      q_in = 1'b1;
      repeat (LAT - 1) tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++;
      if (q_sync_out !== 1'b1 || rise_out !== 1'b1 || count_out !== '0) begin
         errors++;
         $display("[TB] FAIL simul_clear_wins: got q=%b r=%b c=%0d, want q=1 r=1 c=0",
                  q_sync_out, rise_out, count_out);
      end
      q_in = 1'b0;
      repeat (LAT) tick();
      checks++;
      if (q_sync_out !== 1'b0 || fall_out !== 1'b1 || count_out !== CW'(1)) begin
         errors++;
         $display("[TB] FAIL simul_next: got q=%b f=%b c=%0d, want q=0 f=1 c=1",
                  q_sync_out, fall_out, count_out);
      end
   endtask

   initial begin
      rst_in   = 1'b1;
      q_in     = 1'b1;
      clear_in = 1'b0;
      test_reset();
`ifdef GLITCH_FILTER_EN
      test_glitch();
`else
      test_no_filter();
`endif
      test_toggle();
      test_saturation();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
